// File: rtl/result_stream_out_pkg.sv
// Shared widths and state encoding for the result output stage.
package result_stream_out_pkg;

    localparam int unsigned DATA_W = 1024;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned BEATS  = DATA_W / OUT_W;
    localparam int unsigned BEAT_W = 5;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/result_stream_out_if.sv
// Wide vector input plus narrow valid/ready output stream.
interface result_stream_out_if;
    import result_stream_out_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic              m_last;

    modport master (
        input  in_valid,
        input  in_data,
        input  m_ready,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output in_valid,
        output in_data,
        output m_ready,
        input  m_valid,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/rso_row_buf.sv
// ROWS x DATA_W frame buffer: one write port, one registered read port.
module rso_row_buf
    import result_stream_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ROW_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ROW_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [ROWS];
    logic [DATA_W-1:0] r_rd_data;

    // Array write; left unreset so it can map onto a block memory.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; this register doubles as the row hold for serializing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/result_stream_out.sv
// Captures a ROWS-vector frame, then streams it out as OUT_W-bit beats, LSB lane first.
module result_stream_out
    import result_stream_out_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    result_stream_out_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [ROW_W-1:0]            r_wr_row;
    logic [ROW_W-1:0]            w_wr_row_nxt;
    logic [ROW_W-1:0]            r_rd_row;
    logic [ROW_W-1:0]            w_rd_row_nxt;
    logic [BEAT_W-1:0]           r_beat;
    logic [BEAT_W-1:0]           w_beat_nxt;
    logic                        r_done;
    logic                        w_done_nxt;
    logic                        r_overflow;
    logic                        w_overflow_nxt;
    logic                        w_wr_en;
    logic                        w_rd_en;
    logic                        w_xfer;
    logic                        w_last_beat;
    logic                        w_last_row;
    logic [DATA_W-1:0]           w_hold;
    logic [BEATS-1:0][OUT_W-1:0] w_hold_beats;

    rso_row_buf u_row_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_row),
        .i_wr_data (bus.in_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_row),
        .o_rd_data (w_hold)
    );

    assign w_hold_beats = w_hold;
    assign w_xfer       = (r_state == ST_DRAIN) && bus.m_ready;
    assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
    assign w_last_row   = (r_rd_row == ROW_W'(ROWS - 1));

    // Next-state: fill rows, load one row into the hold register, drain its beats.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_row_nxt   = r_wr_row;
        w_rd_row_nxt   = r_rd_row;
        w_beat_nxt     = r_beat;
        w_done_nxt     = 1'b0;
        w_overflow_nxt = r_overflow;
        w_wr_en        = 1'b0;
        w_rd_en        = 1'b0;

        // Words arriving outside FILL are dropped and flagged.
        if (bus.in_valid && (r_state != ST_FILL)) begin
            w_overflow_nxt = 1'b1;
        end

        case (r_state)
            ST_FILL: begin
                if (bus.in_valid) begin
                    w_wr_en      = 1'b1;
                    w_wr_row_nxt = r_wr_row + ROW_W'(1);
                    if (r_wr_row == ROW_W'(ROWS - 1)) begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_rd_en     = 1'b1;
                w_beat_nxt  = '0;
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_xfer) begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                    if (w_last_beat) begin
                        if (w_last_row) begin
                            w_rd_row_nxt = '0;
                            w_state_nxt  = ST_FILL;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_rd_row_nxt = r_rd_row + ROW_W'(1);
                            w_state_nxt  = ST_LOAD;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_wr_row   <= '0;
            r_rd_row   <= '0;
            r_beat     <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_row   <= w_wr_row_nxt;
            r_rd_row   <= w_rd_row_nxt;
            r_beat     <= w_beat_nxt;
            r_done     <= w_done_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign bus.m_valid = (r_state == ST_DRAIN);
    assign bus.m_data  = w_hold_beats[r_beat];
    assign bus.m_last  = (r_state == ST_DRAIN) && w_last_row && w_last_beat;
    assign busy        = (r_state != ST_FILL) || (r_wr_row != '0);
    assign done        = r_done;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_result_stream_out.sv
// Randomized scoreboard bench for result_stream_out.
module tb_result_stream_out;
    import result_stream_out_pkg::*;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
        logic             row_end;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic done;
    logic overflow;

    result_stream_out_if bus ();

    result_stream_out dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int   total    = 0;
    int   bad      = 0;
    exp_t exp_q[$];
    int   rdy_mode = 0;
    int   rdy_cnt  = 0;
    logic exp_ovf  = 1'b0;

    logic             done_pend   = 1'b0;
    logic             bubble_pend = 1'b0;
    logic             prev_stall  = 1'b0;
    logic [OUT_W-1:0] prev_data   = '0;
    logic             prev_last   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Frame word: kind 0 is the {row,beat} pattern, otherwise random.
    function automatic logic [DATA_W-1:0] make_word(input int kind, input int row);
        logic [DATA_W-1:0] w;
        for (int b = 0; b < int'(BEATS); b++) begin
            if (kind == 0) w[b*OUT_W +: OUT_W] = {16'(row), 16'(b)};
            else           w[b*OUT_W +: OUT_W] = $urandom;
        end
        return w;
    endfunction

    // Drives one frame starting at posedge+1; gap<0 means random gaps of 0..3.
    task automatic send_frame(input int kind, input int gap);
        logic [DATA_W-1:0] w;
        exp_t              e;
        int                ng;
        for (int r = 0; r < int'(ROWS); r++) begin
            w = make_word(kind, r);
            bus.in_valid = 1'b1;
            bus.in_data  = w;
            for (int b = 0; b < int'(BEATS); b++) begin
                e.data    = w[b*OUT_W +: OUT_W];
                e.last    = (r == int'(ROWS) - 1) && (b == int'(BEATS) - 1);
                e.row_end = (b == int'(BEATS) - 1) && (r != int'(ROWS) - 1);
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (r != int'(ROWS) - 1) begin
                ng = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                for (int g = 0; g < ng; g++) begin
                    chk("gap_valid", 64'(bus.m_valid), 64'd0);
                    chk("gap_busy", 64'(busy), 64'd1);
                    @(posedge clk); #1;
                end
            end
        end
        chk("load_valid", 64'(bus.m_valid), 64'd0);
        chk("load_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("drain_valid", 64'(bus.m_valid), 64'd1);
    endtask

    // Returns at posedge+1 inside the done cycle.
    task automatic wait_done(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("overflow", 64'(overflow), 64'(exp_ovf));
    endtask

    // Returns at the negedge where the given beat is presented.
    task automatic wait_beat(input logic [OUT_W-1:0] val, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.m_valid && (bus.m_data == val)) begin
                found = 1'b1;
                break;
            end
        end
        chk("beat_found", 64'(found), 64'd1);
    endtask

    // Downstream ready: always, 1,0,0,1 pattern, or random.
    initial begin
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = pat[rdy_cnt % 4];
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
            rdy_cnt++;
        end
    end

    // Monitor: pops expectations on each transfer and checks stalls, bubbles and done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                done_pend   = 1'b0;
                bubble_pend = 1'b0;
                prev_stall  = 1'b0;
            end else begin
                if (done_pend || done) chk("done_pulse", 64'(done), 64'(done_pend));
                if (bubble_pend) chk("row_bubble", 64'(bus.m_valid), 64'd0);
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.m_valid), 64'd1);
                    chk("stall_data", 64'(bus.m_data), 64'(prev_data));
                    chk("stall_last", 64'(bus.m_last), 64'(prev_last));
                end
                done_pend   = 1'b0;
                bubble_pend = 1'b0;
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'(bus.m_data), 64'd0 - 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(bus.m_data), 64'(e.data));
                        chk("beat_last", 64'(bus.m_last), 64'(e.last));
                        done_pend   = e.last;
                        bubble_pend = e.row_end;
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.m_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_last", 64'(bus.m_last), 64'd0);
        chk("rst_data", 64'(bus.m_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame, always ready.
        rdy_mode = 0;
        send_frame(0, 0);
        wait_done(4000);

        // Backpressure 1,0,0,1.
        rdy_mode = 1;
        send_frame(0, 0);
        wait_done(4000);

        // Gapped input.
        rdy_mode = 0;
        send_frame(0, 3);
        wait_done(4000);

        // Overflow during row 2 beat 5.
        rdy_mode = 2;
        send_frame(0, 0);
        wait_beat(32'h0002_0005, 4000);
        bus.in_valid = 1'b1;
        bus.in_data  = make_word(1, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_ovf = 1'b1;
        chk("overflow_set", 64'(overflow), 64'd1);
        wait_done(4000);

        // Back-to-back: next frame's row 0 lands on the done cycle.
        rdy_mode = 2;
        send_frame(1, -1);
        wait_done(4000);
        send_frame(1, -1);
        wait_done(4000);

        // Reset mid-drain at row 7 beat 10.
        rdy_mode = 0;
        send_frame(0, 0);
        wait_beat(32'h0007_000A, 4000);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.m_valid), 64'd0);
        chk("midrst_last", 64'(bus.m_last), 64'd0);
        chk("midrst_data", 64'(bus.m_data), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_ovf = 1'b0;
        @(posedge clk); #1;
        rdy_mode = 2;
        send_frame(0, -1);
        wait_done(4000);

        // Random frames with random gaps and ready.
        for (int k = 0; k < 2; k++) begin
            send_frame(1, -1);
            wait_done(4000);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_stream_out.md
Name: result_stream_out

Overview:
Downstream consumer of the BRAM row-reader stage. It captures one frame of ROWS 1024-bit vectors, which arrive as a back-to-back valid burst with no backpressure, into an internal row buffer. It then serializes the frame as OUT_W-bit beats on a valid/ready stream with a last-beat marker. This is the hand-off from the 1024-bit datapath to the narrow host/DMA output path.

Parameters:
DATA_W, 1024, width of one input vector (64 x 16-bit lanes)
OUT_W, 32, output beat width; DATA_W must be a multiple of OUT_W
ROWS, 16, vectors per frame
ROW_W, 4, row index width, clog2(ROWS)
BEAT_W, 5, beat index width, clog2(DATA_W/OUT_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  in_data holds a vector this cycle; no ready, never stalled
in_data  in  DATA_W  input vector
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts beat
m_data  out  OUT_W  output beat
m_last  out  1  final beat of frame
busy  out  1  high in any state except FILL with 0 rows written
done  out  1  one-cycle pulse after the final beat transfers
overflow  out  1  sticky: in_valid seen while not in FILL

Behaviour:
- Reset: state=FILL, wr_row=0, rd_row=0, beat=0, hold=0. All outputs 0. Buffer contents are not cleared.
- States are FILL, LOAD, DRAIN.
- FILL: on in_valid, write buf[wr_row] <= in_data and increment wr_row. On the ROWS-th write, wr_row wraps to 0 and the next state is LOAD. in_valid low means no write and no state change; gaps between words are legal.
- LOAD: one cycle. hold <= buf[rd_row] (synchronous read), beat <= 0, next state DRAIN. m_valid=0.
- DRAIN: m_valid=1. m_data = hold[beat*OUT_W +: OUT_W], so lane 0 goes first (LSB first).
- A transfer occurs when m_valid && m_ready. On a transfer, beat increments.
- Last beat of a non-final row: rd_row increments, state goes to LOAD. This gives a one-cycle m_valid bubble between rows.
- Last beat of the final row: rd_row=0, state=FILL, done=1 for one cycle.
- m_last = DRAIN && rd_row==ROWS-1 && beat==DATA_W/OUT_W-1.
- Stream rule: while m_valid && !m_ready, m_data and m_last hold stable; m_valid never drops without a transfer.
- Latency: the ROWS-th write occurs at edge E. The state is LOAD in cycle E..E+1, and m_valid first rises after edge E+1.
- Frame length: ROWS*(DATA_W/OUT_W) beats (512 at defaults), plus ROWS-1 bubble cycles.
- Overflow: in_valid in LOAD or DRAIN sets overflow. That word is dropped and the buffer is unmodified. overflow clears only on rst.
- in_valid in the same cycle that done pulses: the state is already FILL, so the word is accepted as row 0 of the next frame.
- Reset mid-DRAIN: the frame is abandoned. m_valid drops immediately (asynchronous) and the next frame restarts at row 0.
- Buffer: inferred ROWS x DATA_W memory, single write port and single synchronous read port. No read-during-write case exists because FILL and LOAD are exclusive.

Decomposition:
- Shared package: state encodings FILL/LOAD/DRAIN, DATA_W=1024, lane width 16, ROWS=16 (shared with the row-reader stage).
- One sub-module: rso_row_buf. It is the simple dual-port ROWS x DATA_W memory with write enable/address/data and a registered read, so it can later be swapped for a block-memory IP.

Test Plan:
- Basic frame: 16 consecutive in_valid words, with row r beat b = {16'(r),16'(b)}; m_ready=1. Expect 512 beats, m_data=0x000r_000b in order, m_last only on 0x000F_001F, one bubble per row boundary, one done pulse.
- Backpressure: same frame, m_ready toggles 1,0,0,1 repeatedly. Expect no loss or duplication, and m_data stable during every stall.
- Gapped input: 16 words with in_valid low for 3 cycles between each. Expect state stays FILL until the 16th word, then identical output to the basic frame.
- Overflow: in_valid pulses at beat 5 of row 2. Expect overflow=1 and sticky, and the output frame unchanged.
- Back-to-back frames: second frame's row 0 in_valid lands on the done cycle. Expect it captured, and frame 2 output correct.
- Reset mid-DRAIN at row 7 beat 10. Expect all outputs 0 immediately and busy=0; a new frame then streams correctly from row 0 beat 0.
